// File: rtl/loader_pkg.sv
// Shared types and constants for the UART frame loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_R = 2'd1,
    GET_G = 2'd2,
    GET_B = 2'd3
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
  localparam int unsigned ADDR_W = 18;
  localparam int unsigned PIX_W  = 24;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags when the limit is hit.
module byte_timeout #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // A byte in the same cycle suppresses expiry, so the data always wins.
  assign expired = en && !clr && (cnt == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Turns a sync-delimited UART byte stream into raster-order RGB pixel writes.
//   state | meaning
//   IDLE  | waiting for the sync byte, other bytes discarded
//   GET_R | waiting for the red byte of the current pixel
//   GET_G | waiting for the green byte
//   GET_B | waiting for the blue byte, then write the pixel
module uart_frame_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMG_W       = 320,
  parameter int unsigned IMG_H       = 240,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  if (IMG_W * IMG_H > (1 << ADDR_W)) begin : g_size_check
    $error("uart_frame_loader: IMG_W*IMG_H does not fit in the pixel address");
  end

  loader_state_t     state;
  logic [7:0]        r_q;
  logic [7:0]        g_q;
  logic [ADDR_W-1:0] addr_q;
  logic              expired;

  byte_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_byte_timeout (
    .clk     (CLK100MHZ),
    .rst_n   (CPU_RESETN),
    .clr     (rx_ready),
    .en      (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state       <= IDLE;
      r_q         <= '0;
      g_q         <= '0;
      addr_q      <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      if (state == IDLE) begin
        if (rx_ready && rx_data == SYNC_BYTE) begin
          state  <= GET_R;
          addr_q <= '0;
          busy   <= 1'b1;
        end
      end else if (rx_ready) begin
        // Inside a frame every byte is pixel data, including the sync value.
        case (state)
          GET_R: begin
            r_q   <= rx_data;
            state <= GET_G;
          end
          GET_G: begin
            g_q   <= rx_data;
            state <= GET_B;
          end
          default: begin
            wr_en   <= 1'b1;
            wr_addr <= addr_q;
            wr_data <= {r_q, g_q, rx_data};
            if (addr_q == LAST_ADDR) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              addr_q     <= '0;
              state      <= IDLE;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              state  <= GET_R;
            end
          end
        endcase
      end else if (expired) begin
        err_timeout <= 1'b1;
        busy        <= 1'b0;
        r_q         <= '0;
        g_q         <= '0;
        addr_q      <= '0;
        state       <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader with a queue-based reference model of the byte stream.
module tb_uart_frame_loader;

  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 2;
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned TO    = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        err_timeout;

  uart_frame_loader #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .SYNC_BYTE   (8'hAA),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a frame is "sync, then groups of three bytes"; silence of TO cycles aborts.
  bit          m_in_frame = 0;
  int          m_pix = 0;
  int          m_idle = 0;
  logic [7:0]  m_pend[$];
  logic        e_wr_en = 0, e_fd = 0, e_err = 0, e_busy = 0;
  logic [17:0] e_addr = '0;
  logic [23:0] e_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_frame = 0; m_pix = 0; m_idle = 0; m_pend.delete();
      e_wr_en = 0; e_fd = 0; e_err = 0; e_busy = 0; e_addr = '0; e_data = '0;
    end else begin
      e_wr_en = 0; e_fd = 0; e_err = 0;
      if (rx_ready) begin
        m_idle = 0;
        if (!m_in_frame) begin
          if (rx_data == 8'hAA) begin
            m_in_frame = 1; m_pix = 0; m_pend.delete(); e_busy = 1;
          end
        end else begin
          m_pend.push_back(rx_data);
          if (m_pend.size() == 3) begin
            e_wr_en = 1;
            e_addr  = 18'(m_pix);
            e_data  = {m_pend[0], m_pend[1], m_pend[2]};
            m_pend.delete();
            if (m_pix == NPIX - 1) begin
              e_fd = 1; e_busy = 0; m_in_frame = 0;
            end else begin
              m_pix++;
            end
          end
        end
      end else if (m_in_frame) begin
        m_idle++;
        if (m_idle == TO) begin
          e_err = 1; e_busy = 0; m_in_frame = 0; m_pend.delete();
        end
      end
    end
  end

  logic [41:0] wlog[$];
  int          err_cnt = 0;
  int          fd_cnt = 0;
  logic [17:0] fd_addr = '1;

  always @(negedge clk) begin
    check("cycle", 64'({wr_en, frame_done, err_timeout, busy, wr_addr, wr_data}),
                   64'({e_wr_en, e_fd, e_err, e_busy, e_addr, e_data}));
    if (wr_en) wlog.push_back({wr_addr, wr_data});
    if (err_timeout) err_cnt++;
    if (frame_done) begin fd_cnt++; fd_addr = wr_addr; end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("reset_outputs", 64'({wr_en, frame_done, err_timeout, busy, wr_addr, wr_data}), 64'd0);

    send(8'h11); send(8'h55); idle(2);
    check("noise_no_write", 64'(wlog.size()), 64'd0);
    check("noise_busy", 64'(busy), 64'd0);

    send(8'hAA); send(8'h12); send(8'h34); send(8'h56); idle(2);
    check("first_write_count", 64'(wlog.size()), 64'd1);
    check("first_write", 64'(wlog[0]), 64'({18'd0, 24'h123456}));
    check("first_busy", 64'(busy), 64'd1);
    idle(TO + 5);
    check("timeout1_count", 64'(err_cnt), 64'd1);

    send(8'hAA);
    for (int i = 0; i < 24; i++) send(8'(8'h20 + i));
    idle(2);
    check("frame_write_count", 64'(wlog.size()), 64'd9);
    for (int p = 0; p < 8; p++)
      check("frame_addr", 64'(wlog[1 + p][41:24]), 64'(p));
    check("frame_last_data", 64'(wlog[8][23:0]), 64'h353637);
    check("frame_done_count", 64'(fd_cnt), 64'd1);
    check("frame_done_addr", 64'(fd_addr), 64'd7);
    check("frame_busy_after", 64'(busy), 64'd0);

    send(8'hAA); send(8'hAA); send(8'hBB); send(8'hCC); idle(2);
    check("sync_as_data", 64'(wlog[9]), 64'({18'd0, 24'hAABBCC}));
    idle(TO + 5);

    send(8'hAA); send(8'h01); send(8'h02); idle(TO + 5);
    check("timeout_count", 64'(err_cnt), 64'd3);
    check("timeout_no_write", 64'(wlog.size()), 64'd10);
    check("timeout_busy", 64'(busy), 64'd0);
    send(8'hAA); send(8'h07); send(8'h08); send(8'h09); idle(2);
    check("after_timeout_write", 64'(wlog[10]), 64'({18'd0, 24'h070809}));
    idle(TO + 5);

    send(8'hAA); send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D); idle(1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_frame", 64'({wr_en, frame_done, err_timeout, busy, wr_addr, wr_data}), 64'd0);
    rst_n = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); idle(3);
    check("post_reset_no_write", 64'(wlog.size()), 64'd12);
    send(8'hAA); send(8'h04); send(8'h05); send(8'h06); idle(2);
    check("post_reset_write", 64'(wlog[12]), 64'({18'd0, 24'h040506}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
